fsm_ctx_sched: RTL

Round-robin scheduler that time-shares a single 2-bit run-of-ones detector FSM among `N_CH` bit-serial requesters. It keeps a per-channel saved state (context) and grants at most one channel per cycle. For the granted channel it loads the context into the shared next-state logic, writes the result back, and reports the Moore output on a registered result port. It sits between the per-lane bit sources and the downstream event collector.

---
 rtl/fsm_ctx_sched_pkg.sv | 30 +++
 rtl/fsm_ctx_sched_if.sv | 26 ++
 rtl/fsm_ctx_sched_rr_arbiter.sv | 28 ++
 rtl/fsm_ctx_sched.sv | 111 +++++++++++
 4 files changed

// File: rtl/fsm_ctx_sched_pkg.sv
// Shared definitions for the context-switched run-of-ones detector:
// state encoding plus next-state and Moore-output functions.
package fsm_sched_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  function automatic state_t fsm_next(input state_t s, input logic b);
    state_t n;
    if (!b) begin
      n = S0;
    end else begin
      case (s)
        S0:      n = S1;
        S1:      n = S2;
        default: n = S3;
      endcase
    end
    return n;
  endfunction

  function automatic logic fsm_out(input state_t s);
    return (s == S2);
  endfunction

endpackage

// File: rtl/fsm_ctx_sched_if.sv
// Requester and result handshake bundle for fsm_ctx_sched.
// master = bit sources / downstream collector side, slave = the scheduler.
interface fsm_sched_if #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
);
  logic [N_CH-1:0] req_valid;
  logic [N_CH-1:0] req_bit;
  logic [N_CH-1:0] req_ready;
  logic [N_CH-1:0] ch_clr;
  logic            det_valid;
  logic            det_ready;
  logic [CH_W-1:0] det_ch;
  logic            det_hit;
  logic [1:0]      det_state;

  modport master (
    output req_valid, req_bit, ch_clr, det_ready,
    input  req_ready, det_valid, det_ch, det_hit, det_state
  );

  modport slave (
    input  req_valid, req_bit, ch_clr, det_ready,
    output req_ready, det_valid, det_ch, det_hit, det_state
  );
endinterface

// File: rtl/fsm_ctx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request
// found searching upward from ptr, wrapping at N-1 back to 0.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsm_ctx_sched.sv
// Round-robin scheduler time-sharing one run-of-ones detector across N_CH
// bit-serial channels. Optional per-channel hit counters: FSM_SCHED_HIT_CNT_EN.
module fsm_ctx_sched
  import fsm_sched_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  fsm_sched_if.slave        bus
`ifdef FSM_SCHED_HIT_CNT_EN
  ,
  output logic [N_CH*8-1:0] hit_cnt
`endif
);

  state_t          ctx [N_CH];
  logic [CH_W-1:0] rr_ptr;
  logic [N_CH-1:0] elig_p0;
  logic [N_CH-1:0] gnt_p0;
  logic [N_CH-1:0] rdy_p0;
  logic            stall_p0;
  logic            acc_p0;
  logic [CH_W-1:0] acc_ch_p0;
  logic [CH_W-1:0] nxt_ptr_p0;
  state_t          nxt_p0;

  logic            vld_p1;
  logic [CH_W-1:0] det_ch_p1;
  logic            det_hit_p1;
  state_t          det_state_p1;

  // ---- p0: arbitration and shared next-state logic ----
  assign elig_p0  = bus.req_valid & ~bus.ch_clr;
  assign stall_p0 = vld_p1 & ~bus.det_ready;

  rr_arbiter #(.N(N_CH)) u_arb (
    .req (elig_p0),
    .ptr (rr_ptr),
    .gnt (gnt_p0)
  );

  assign rdy_p0        = stall_p0 ? '0 : gnt_p0;
  assign acc_p0        = |rdy_p0;
  assign bus.req_ready = rdy_p0;

  always_comb begin
    acc_ch_p0 = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_p0[i]) acc_ch_p0 = CH_W'(i);
    end
  end

  assign nxt_p0     = fsm_next(ctx[acc_ch_p0], bus.req_bit[acc_ch_p0]);
  assign nxt_ptr_p0 = (acc_ch_p0 == CH_W'(N_CH - 1)) ? '0 : acc_ch_p0 + 1'b1;

  // ---- p1: context write-back and result register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      det_ch_p1    <= '0;
      det_hit_p1   <= 1'b0;
      det_state_p1 <= S0;
      rr_ptr       <= '0;
      for (int i = 0; i < N_CH; i++) ctx[i] <= S0;
    end else begin
      // A clear wins over everything, including a stall.
      for (int i = 0; i < N_CH; i++) begin
        if (bus.ch_clr[i])  ctx[i] <= S0;
        else if (rdy_p0[i]) ctx[i] <= nxt_p0;
      end
      if (!stall_p0) begin
        vld_p1 <= acc_p0;
        if (acc_p0) begin
          det_ch_p1    <= acc_ch_p0;
          det_state_p1 <= nxt_p0;
          det_hit_p1   <= fsm_out(nxt_p0);
          rr_ptr       <= nxt_ptr_p0;
        end
      end
    end
  end

  assign bus.det_valid = vld_p1;
  assign bus.det_ch    = det_ch_p1;
  assign bus.det_hit   = det_hit_p1;
  assign bus.det_state = det_state_p1;

`ifdef FSM_SCHED_HIT_CNT_EN
  logic [7:0] hcnt [N_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) hcnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (bus.ch_clr[i])
          hcnt[i] <= 8'd0;
        else if (rdy_p0[i] && (nxt_p0 == S2) && (hcnt[i] != 8'hFF))
          hcnt[i] <= hcnt[i] + 8'd1;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_hit
    assign hit_cnt[8*g +: 8] = hcnt[g];
  end
`endif

endmodule
